glenn_8to3_encoder: RTL and testbench
=====================================

// Module: glenn_8to3_encoder
// PURPOSE
//   Clocked 8-to-3 priority encoder. It is the reverse path of the 3-bit decoder.
//   Eight request lines are latched into a pending register.
//   The highest-priority pending line is presented as a 3-bit code with a
//   valid/ack handshake. Sits in front of any logic consuming one-of-eight
//   events (interrupt/event funnelling).
// PARAMETERS
//   HIGH_FIRST  1  1: index 7 has top priority; 0: index 0 has top priority
// PORTS
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   en       in   1  capture enable; 0 = in8 ignored; pending bits kept
//   clr      in   1  synchronous flush of pending bits and handshake
//   in8      in   8  request lines, level-sampled every clock, multi-hot allowed
//   ack      in   1  consumer accepts out3; only meaningful while valid=1
//   out3     out  3  encoded index of the presented request
//   valid    out  1  out3 holds a request awaiting ack
//   pending  out  8  current pending register (debug/status)
//   more     out  1  valid=1 and at least one other pending bit set
// BEHAVIOUR
//   Reset (rst_n=0, async): pend=0, out3=0, valid=0, more=0, FSM=IDLE.
//   Pending update at every edge:
//     pend <= (pend & ~clr_mask) | (en ? in8 : 8'h00)
//     clr_mask = onehot(out3) when in PRESENT with ack=1, else 0.
//     Set wins: a bit re-requested in its own ack cycle stays pending.
//   clr=1 overrides all: pend<=0, valid<=0, out3 unchanged, FSM->IDLE, in8 ignored.
//   FSM, 2 states:
//     IDLE:    if pend!=0 -> out3<=prio_enc(pend), valid<=1, ->PRESENT.
//              Uses the registered pend, not in8.
//     PRESENT: out3 and valid held stable until ack=1.
//              Higher-priority arrivals do NOT pre-empt the presented code.
//              ack=1 -> valid<=0, pend[out3] cleared, ->IDLE.
//   Latency: in8[i] high at edge k -> pend[i]=1 after k.
//     If IDLE, valid=1 and out3=i after edge k+1.
//     Ack at edge m -> valid=0 after m; next valid earliest after m+1.
//     Peak rate: one code per 2 cycles.
//   ack while valid=0: ignored, no pend change.
//   en=0 in PRESENT: handshake continues normally; only new captures are blocked.
//   more = valid & |(pend & ~onehot(out3)), combinational from registers.
//   Reset mid-handshake: all state lost; the consumer must treat valid as dropped.
// STRUCTURE
//   Shared package glenn_codec_pkg:
//     state typedef {IDLE, PRESENT}
//     functions onehot3to8() and prio_enc8to3(pend, high_first)
//     The existing decoder reuses onehot3to8 as its decode function.
//   One sub-module is natural: glenn_prio_enc8, a pure-combinational encoder
//     with outputs idx[2:0] and any. The FSM and pend register live in the top.
// TESTING
//   1 Reset: rst_n=0 mid-PRESENT with pend=8'hFF -> out3=0, valid=0,
//     pending=0 immediately, without waiting for a clock edge.
//   2 Single request: en=1, in8=8'h10 for 1 cycle -> valid=1, out3=4
//     after 2nd edge; ack 1 cycle -> valid=0, pending=0.
//   3 Priority: HIGH_FIRST=1, in8=8'h81 -> out3=7, more=1.
//     After ack -> out3=0, more=0.
//     Repeat with HIGH_FIRST=0 -> order 0 then 7.
//   4 No pre-emption and set-wins: present out3=2; raise in8[7] -> out3 stays 2.
//     Ack with in8=8'h04 held -> pend[2] stays 1, then 7 served, then 2 again.
//   5 Enable/flush: en=0, in8=8'hFF -> pending stays 0.
//     With pend=8'h0C, clr=1 -> pending=0, valid=0 next cycle.
//   6 Spurious ack: ack=1 in IDLE with pend=0 -> no state change, valid=0.

Source files
------------

// File: rtl/glenn_8to3_encoder_pkg.sv
// Shared codec package: FSM state type plus the one-hot decode and
// priority-encode helpers used by both the encoder and the 3-bit decoder.
package glenn_codec_pkg;

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_e;

  // 3-bit index to one-hot 8-bit mask (also the decoder's decode function)
  function automatic logic [7:0] onehot3to8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  // Index of the winning set bit; high_first picks bit 7 as top priority.
  // Returns 0 when nothing is set.
  function automatic logic [2:0] prio_enc8to3(input logic [7:0] pend,
                                              input logic       high_first);
    logic [2:0] r;
    r = '0;
    if (high_first) begin
      for (int i = 0; i < 8; i++)
        if (pend[i]) r = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (pend[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/glenn_8to3_encoder_if.sv
// Request/handshake bundle between the producer and the 8-to-3 encoder.
interface glenn_8to3_encoder_if;
  logic       en;
  logic       clr;
  logic [7:0] in8;
  logic       ack;
  logic [2:0] out3;
  logic       valid;
  logic [7:0] pending;
  logic       more;

  // Producer / consumer side
  modport master (output en, clr, in8, ack,
                  input  out3, valid, pending, more);
  // Encoder side
  modport slave  (input  en, clr, in8, ack,
                  output out3, valid, pending, more);
endinterface

// File: rtl/glenn_8to3_encoder_prio_enc8.sv
// Pure combinational 8-to-3 priority encoder.
module glenn_prio_enc8
  import glenn_codec_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       any_o
);
  assign idx_o = prio_enc8to3(req_i, HIGH_FIRST);
  assign any_o = |req_i;
endmodule

// File: rtl/glenn_8to3_encoder.sv
// Clocked 8-to-3 priority encoder: latches requests into a pending register
// and presents the winning index with a valid/ack handshake. A presented code
// is never pre-empted; it is held until acked.
module glenn_8to3_encoder
  import glenn_codec_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  glenn_8to3_encoder_if.slave        bus
);

  state_e     state_q, state_d;
  logic [7:0] pend_q,  pend_d;
  logic [2:0] out3_q,  out3_d;
  logic       valid_q, valid_d;
  logic [7:0] clr_mask;
  logic [2:0] enc_idx;
  logic       enc_any;

  // Encode from the registered pending bits, never straight from in8
  glenn_prio_enc8 #(.HIGH_FIRST(HIGH_FIRST)) u_enc (
    .req_i (pend_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Next-state: flush beats everything; otherwise ack retires the presented
  // bit while a same-cycle re-request of that bit keeps it pending (set wins)
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    out3_d   = out3_q;
    valid_d  = valid_q;
    clr_mask = '0;
    if (bus.clr) begin
      pend_d  = '0;
      valid_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_any) begin
            out3_d  = enc_idx;
            valid_d = 1'b1;
            state_d = PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            clr_mask = onehot3to8(out3_q);
            valid_d  = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      pend_d = (pend_q & ~clr_mask) | (bus.en ? bus.in8 : 8'h00);
    end
  end

  // State and pending register, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      out3_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out3_q  <= out3_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out3    = out3_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pend_q;
  assign bus.more    = valid_q & |(pend_q & ~onehot3to8(out3_q));

endmodule

// File: tb/tb_glenn_8to3_encoder.sv
// Directed bench for the 8-to-3 encoder; a second instance covers low-first
// priority.
module tb_glenn_8to3_encoder;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  glenn_8to3_encoder_if a_if ();
  glenn_8to3_encoder_if b_if ();

  glenn_8to3_encoder #(.HIGH_FIRST(1'b1)) u_dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  glenn_8to3_encoder #(.HIGH_FIRST(1'b0)) u_dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.en = 0; a_if.clr = 0; a_if.in8 = 8'h00; a_if.ack = 0;
    b_if.en = 0; b_if.clr = 0; b_if.in8 = 8'h00; b_if.ack = 0;
    tick(); tick();
    chk("rst_out3",    32'(a_if.out3),    32'd0);
    chk("rst_valid",   32'(a_if.valid),   32'd0);
    chk("rst_pending", 32'(a_if.pending), 32'h00);
    chk("rst_more",    32'(a_if.more),    32'd0);
    rst_n = 1'b1;

    // 1: async reset mid-PRESENT with all bits pending
    a_if.en = 1; a_if.in8 = 8'hFF;
    tick();
    a_if.en = 0; a_if.in8 = 8'h00;
    chk("t1_pend_ff",  32'(a_if.pending), 32'hFF);
    chk("t1_valid_lat",32'(a_if.valid),   32'd0);
    tick();
    chk("t1_valid",    32'(a_if.valid),   32'd1);
    chk("t1_out3",     32'(a_if.out3),    32'd7);
    chk("t1_more",     32'(a_if.more),    32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_out3",  32'(a_if.out3),    32'd0);
    chk("t1_async_valid", 32'(a_if.valid),   32'd0);
    chk("t1_async_pend",  32'(a_if.pending), 32'h00);
    tick();
    rst_n = 1'b1;

    // 2: single request, two-edge latency, ack retires it
    a_if.en = 1; a_if.in8 = 8'h10;
    tick();
    a_if.en = 0; a_if.in8 = 8'h00;
    chk("t2_pend",   32'(a_if.pending), 32'h10);
    chk("t2_vld0",   32'(a_if.valid),   32'd0);
    tick();
    chk("t2_valid",  32'(a_if.valid),   32'd1);
    chk("t2_out3",   32'(a_if.out3),    32'd4);
    chk("t2_more",   32'(a_if.more),    32'd0);
    a_if.ack = 1;
    tick();
    a_if.ack = 0;
    chk("t2_ack_valid", 32'(a_if.valid),   32'd0);
    chk("t2_ack_pend",  32'(a_if.pending), 32'h00);

    // 3: priority order, both polarities
    a_if.en = 1; a_if.in8 = 8'h81;
    b_if.en = 1; b_if.in8 = 8'h81;
    tick();
    a_if.en = 0; a_if.in8 = 8'h00;
    b_if.en = 0; b_if.in8 = 8'h00;
    tick();
    chk("t3_hi_out3", 32'(a_if.out3), 32'd7);
    chk("t3_hi_more", 32'(a_if.more), 32'd1);
    chk("t3_lo_out3", 32'(b_if.out3), 32'd0);
    chk("t3_lo_more", 32'(b_if.more), 32'd1);
    a_if.ack = 1; b_if.ack = 1;
    tick();
    a_if.ack = 0; b_if.ack = 0;
    chk("t3_hi_pend1", 32'(a_if.pending), 32'h01);
    chk("t3_lo_pend1", 32'(b_if.pending), 32'h80);
    chk("t3_hi_gap",   32'(a_if.valid),   32'd0);
    tick();
    chk("t3_hi_out3b", 32'(a_if.out3),  32'd0);
    chk("t3_hi_valb",  32'(a_if.valid), 32'd1);
    chk("t3_hi_moreb", 32'(a_if.more),  32'd0);
    chk("t3_lo_out3b", 32'(b_if.out3),  32'd7);
    chk("t3_lo_moreb", 32'(b_if.more),  32'd0);
    a_if.ack = 1; b_if.ack = 1;
    tick();
    a_if.ack = 0; b_if.ack = 0;
    chk("t3_hi_pend0", 32'(a_if.pending), 32'h00);
    chk("t3_lo_pend0", 32'(b_if.pending), 32'h00);

    // 4: no pre-emption, and set wins over ack clear
    a_if.en = 1; a_if.in8 = 8'h04;
    tick();
    a_if.in8 = 8'h00;
    tick();
    chk("t4_out3_2", 32'(a_if.out3), 32'd2);
    a_if.in8 = 8'h80;
    tick();
    chk("t4_pend84", 32'(a_if.pending), 32'h84);
    tick();
    chk("t4_nopre",  32'(a_if.out3),  32'd2);
    chk("t4_nopre_v",32'(a_if.valid), 32'd1);
    chk("t4_more",   32'(a_if.more),  32'd1);
    a_if.in8 = 8'h04; a_if.ack = 1;
    tick();
    a_if.in8 = 8'h00; a_if.ack = 0; a_if.en = 0;
    chk("t4_setwin", 32'(a_if.pending), 32'h84);
    chk("t4_gap",    32'(a_if.valid),   32'd0);
    tick();
    chk("t4_out3_7", 32'(a_if.out3), 32'd7);
    chk("t4_more7",  32'(a_if.more), 32'd1);
    a_if.ack = 1;
    tick();
    a_if.ack = 0;
    chk("t4_pend04", 32'(a_if.pending), 32'h04);
    tick();
    chk("t4_again2", 32'(a_if.out3),  32'd2);
    chk("t4_again_v",32'(a_if.valid), 32'd1);
    a_if.ack = 1;
    tick();
    a_if.ack = 0;
    chk("t4_done_p", 32'(a_if.pending), 32'h00);
    chk("t4_done_v", 32'(a_if.valid),   32'd0);

    // 5: capture disabled, then synchronous flush
    a_if.en = 0; a_if.in8 = 8'hFF;
    tick(); tick();
    chk("t5_en0_pend",  32'(a_if.pending), 32'h00);
    chk("t5_en0_valid", 32'(a_if.valid),   32'd0);
    a_if.en = 1; a_if.in8 = 8'h0C;
    tick();
    a_if.en = 0; a_if.in8 = 8'h00;
    chk("t5_pend0c", 32'(a_if.pending), 32'h0C);
    a_if.clr = 1;
    tick();
    a_if.clr = 0;
    chk("t5_clr_pend",  32'(a_if.pending), 32'h00);
    chk("t5_clr_valid", 32'(a_if.valid),   32'd0);
    chk("t5_clr_out3",  32'(a_if.out3),    32'd2);
    tick();
    chk("t5_clr_hold",  32'(a_if.valid),   32'd0);

    // 6: ack with nothing presented is ignored
    a_if.ack = 1;
    tick();
    a_if.ack = 0;
    chk("t6_valid", 32'(a_if.valid),   32'd0);
    chk("t6_pend",  32'(a_if.pending), 32'h00);
    chk("t6_out3",  32'(a_if.out3),    32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
